// File: rtl/washing_machine_if.sv
// washing_machine_if: front-panel, sensor and actuator signals of the washing machine.
interface washing_machine_if;
    logic [1:0] SELECTOR;
    logic       START;
    logic       WATER_LEVEL_SENSOR;
    logic       TEMP_SENSOR;
    logic       DOOR_LOCK;
    logic       WATER_VALVE;
    logic       DETERGENT_HATCH;
    logic       WATER_HEATER;
    logic       DRUM_MOTOR;
    logic       WATER_PUMP;
    logic [2:0] CURRENT_STATE;
    modport master (
        output SELECTOR, START, WATER_LEVEL_SENSOR, TEMP_SENSOR,
        input  DOOR_LOCK, WATER_VALVE, DETERGENT_HATCH, WATER_HEATER, DRUM_MOTOR, WATER_PUMP, CURRENT_STATE
    );
    modport slave (
        input  SELECTOR, START, WATER_LEVEL_SENSOR, TEMP_SENSOR,
        output DOOR_LOCK, WATER_VALVE, DETERGENT_HATCH, WATER_HEATER, DRUM_MOTOR, WATER_PUMP, CURRENT_STATE
    );
endinterface

// File: rtl/washing_machine.sv
// washing_machine: Moore FSM sequencing lock, fill, optional heat, wash, drain, spin and unlock.
module washing_machine #(
    parameter int WASH_UNIT    = 8,
    parameter int DRAIN_CYCLES = 16,
    parameter int SPIN_CYCLES  = 16
) (
    input logic              clk,
    input logic              rst_n,
    washing_machine_if.slave bus
);
    typedef enum logic [2:0] {IDLE, FILL, HEAT, WASH, DRAIN, SPIN, DONE} state_t;
    state_t     state, nxt;
    logic [7:0] cnt;
    logic [1:0] prog;
    logic [7:0] wash_len;
    logic       timed;
    assign wash_len = 8'(WASH_UNIT) * (8'(prog) + 8'd1);
    assign timed    = state inside {WASH, DRAIN, SPIN};
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = bus.START ? FILL : IDLE;
            FILL:    nxt = bus.WATER_LEVEL_SENSOR ? (prog[1] ? HEAT : WASH) : FILL;
            HEAT:    nxt = bus.TEMP_SENSOR ? WASH : HEAT;
            WASH:    nxt = (cnt == wash_len - 8'd1) ? DRAIN : WASH;
            DRAIN:   nxt = (cnt == 8'(DRAIN_CYCLES - 1)) ? SPIN : DRAIN;
            SPIN:    nxt = (cnt == 8'(SPIN_CYCLES - 1)) ? DONE : SPIN;
            default: nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= 8'd0;
            prog  <= 2'b00;
        end else begin
            state <= nxt;
            cnt   <= (nxt != state) ? 8'd0 : cnt + {7'd0, timed};
            if (state == IDLE && bus.START) prog <= bus.SELECTOR;
        end
    end
    // Pure state decode: no input reaches an output combinationally.
    assign bus.DOOR_LOCK       = state inside {FILL, HEAT, WASH, DRAIN, SPIN};
    assign bus.WATER_VALVE     = state == FILL;
    assign bus.DETERGENT_HATCH = state == FILL;
    assign bus.WATER_HEATER    = state == HEAT;
    assign bus.DRUM_MOTOR      = state inside {WASH, SPIN};
    assign bus.WATER_PUMP      = state inside {DRAIN, SPIN};
    assign bus.CURRENT_STATE   = state;
endmodule

// File: tb/tb_washing_machine.sv
// tb_washing_machine: directed test-plan scenarios plus random stimulus, checked every cycle
// against a phase/countdown model of the wash programme.
module tb_washing_machine;
    localparam int WU = 8, DC = 16, SC = 16;
    logic clk = 1'b0;
    logic rst_n;
    int   tests = 0;
    int   fails = 0;
    washing_machine_if bus();
    washing_machine #(.WASH_UNIT(WU), .DRAIN_CYCLES(DC), .SPIN_CYCLES(SC)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );
    always #5 clk = ~clk;
    // {lock, valve, hatch, heater, motor, pump} per phase, IDLE..DONE
    logic [5:0] out_tab [0:6] = '{6'b000000, 6'b111000, 6'b100100, 6'b100010,
                                  6'b100001, 6'b100011, 6'b000000};
    int         m_st  = 0;
    int         m_rem = 0;
    logic [1:0] m_prog = 2'b00;
    bit         armed = 1'b0;
    function automatic logic [5:0] outs();
        return {bus.DOOR_LOCK, bus.WATER_VALVE, bus.DETERGENT_HATCH,
                bus.WATER_HEATER, bus.DRUM_MOTOR, bus.WATER_PUMP};
    endfunction
    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask
    // Model: phase number plus remaining cycles of the current timed phase.
    always @(posedge clk) begin
        if (!rst_n) begin
            m_st = 0; m_rem = 0; m_prog = 2'b00; armed = 1'b1;
        end else begin
            case (m_st)
                0: if (bus.START) begin m_prog = bus.SELECTOR; m_st = 1; end
                1: if (bus.WATER_LEVEL_SENSOR) begin
                       m_st = m_prog[1] ? 2 : 3;
                       m_rem = WU * (int'(m_prog) + 1);
                   end
                2: if (bus.TEMP_SENSOR) begin m_st = 3; m_rem = WU * (int'(m_prog) + 1); end
                3: begin m_rem--; if (m_rem == 0) begin m_st = 4; m_rem = DC; end end
                4: begin m_rem--; if (m_rem == 0) begin m_st = 5; m_rem = SC; end end
                5: begin m_rem--; if (m_rem == 0) m_st = 6; end
                default: m_st = 0;
            endcase
        end
    end
    always @(negedge clk) begin
        if (armed) begin
            check("model_state", int'(bus.CURRENT_STATE), m_st);
            check("model_outputs", int'(outs()), int'(out_tab[m_st]));
        end
    end
    task automatic measure(input int st, output int n);
        n = 0;
        while (int'(bus.CURRENT_STATE) == st && n < 400) begin
            n++;
            @(negedge clk);
        end
    endtask
    task automatic run_to_idle(output int heat_seen);
        int n = 0;
        heat_seen = 0;
        while (bus.CURRENT_STATE != 3'd0 && n < 400) begin
            if (bus.WATER_HEATER) heat_seen = 1;
            n++;
            @(negedge clk);
        end
        check("reach_idle", int'(bus.CURRENT_STATE), 0);
    endtask
    task automatic pulse_level();
        bus.WATER_LEVEL_SENSOR = 1'b1;
        @(negedge clk);
        bus.WATER_LEVEL_SENSOR = 1'b0;
    endtask
    task automatic pulse_temp();
        bus.TEMP_SENSOR = 1'b1;
        @(negedge clk);
        bus.TEMP_SENSOR = 1'b0;
    endtask
    task automatic start_prog(input logic [1:0] p);
        bus.SELECTOR = p;
        bus.START = 1'b1;
        @(negedge clk);
        bus.START = 1'b0;
    endtask
    initial begin
        int n, h;
        rst_n = 1'b0;
        bus.START = 1'b1;
        bus.SELECTOR = 2'b11;
        bus.WATER_LEVEL_SENSOR = 1'b0;
        bus.TEMP_SENSOR = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_state", int'(bus.CURRENT_STATE), 0);
        check("reset_outputs", int'(outs()), 0);
        rst_n = 1'b1;
        @(negedge clk);
        bus.START = 1'b0;
        check("start_to_fill", int'(bus.CURRENT_STATE), 1);
        check("fill_outputs", int'(outs()), 6'b111000);
        pulse_level();
        check("p3_heat", int'(bus.CURRENT_STATE), 2);
        check("heat_outputs", int'(outs()), 6'b100100);
        pulse_temp();
        check("p3_wash", int'(bus.CURRENT_STATE), 3);
        check("wash_outputs", int'(outs()), 6'b100010);
        n = 0;
        while (bus.CURRENT_STATE == 3'd3 && n < 400) begin
            bus.START = n[0];
            bus.SELECTOR = 2'b00;
            n++;
            @(negedge clk);
        end
        bus.START = 1'b0;
        check("p3_wash_len_ignoring_inputs", n, 32);
        check("drain_state", int'(bus.CURRENT_STATE), 4);
        check("drain_outputs", int'(outs()), 6'b100001);
        measure(4, n);
        check("drain_len", n, 16);
        check("spin_outputs", int'(outs()), 6'b100011);
        measure(5, n);
        check("spin_len", n, 16);
        check("done_state", int'(bus.CURRENT_STATE), 6);
        measure(6, n);
        check("done_len", n, 1);
        check("idle_outputs", int'(outs()), 0);
        @(negedge clk);
        check("stays_idle", int'(bus.CURRENT_STATE), 0);
        start_prog(2'b00);
        check("p0_fill", int'(bus.CURRENT_STATE), 1);
        pulse_level();
        check("p0_skips_heat", int'(bus.CURRENT_STATE), 3);
        measure(3, n);
        check("p0_wash_len", n, 8);
        run_to_idle(h);
        check("p0_heater_never_on", h, 0);
        start_prog(2'b11);
        pulse_temp();
        check("lost_pulse_still_fill", int'(bus.CURRENT_STATE), 1);
        pulse_level();
        repeat (5) @(negedge clk);
        check("lost_pulse_waits_heat", int'(bus.CURRENT_STATE), 2);
        pulse_temp();
        check("second_temp_to_wash", int'(bus.CURRENT_STATE), 3);
        run_to_idle(h);
        start_prog(2'b01);
        pulse_level();
        n = 0;
        while (bus.CURRENT_STATE != 3'd5 && n < 400) begin
            n++;
            @(negedge clk);
        end
        check("reached_spin", int'(bus.CURRENT_STATE), 5);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("midreset_state", int'(bus.CURRENT_STATE), 0);
        check("midreset_outputs", int'(outs()), 0);
        repeat (3) @(negedge clk);
        check("no_restart_without_start", int'(bus.CURRENT_STATE), 0);
        repeat (3000) begin
            rst_n = $urandom_range(0, 199) != 0;
            bus.START = $urandom_range(0, 15) == 0;
            bus.SELECTOR = 2'($urandom);
            bus.WATER_LEVEL_SENSOR = $urandom_range(0, 7) == 0;
            bus.TEMP_SENSOR = $urandom_range(0, 7) == 0;
            @(negedge clk);
        end
        rst_n = 1'b1;
        bus.START = 1'b0;
        bus.WATER_LEVEL_SENSOR = 1'b0;
        bus.TEMP_SENSOR = 1'b0;
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d failed so far", fails);
        $fatal(1, "timeout");
    end
endmodule
